// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and operand-forwarding control for a 5-stage in-order pipeline.
// Tracks shadow copies of the EX, MEM and WB stages. It produces the EX operand
// forwarding selects and a one-cycle load-use stall.
// Optional stall statistics counter: define HAZARD_STALL_STATS_EN to build it.
module hazard_fwd_ctrl #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   id_valid,
    input  logic [REG_AW-1:0]      id_rs1,
    input  logic [REG_AW-1:0]      id_rs2,
    input  logic                   id_use_rs1,
    input  logic                   id_use_rs2,
    input  logic [REG_AW-1:0]      id_rd,
    input  logic                   id_reg_write,
    input  logic                   id_mem_read,
    input  logic                   flush,
    output logic [1:0]             fwd_a_sel,
    output logic [1:0]             fwd_b_sel,
    output logic                   stall,
    output logic [STALL_CNT_W-1:0] stall_count
);

    // EX shadow stage
    logic              ex_valid_q, ex_use_rs1_q, ex_use_rs2_q, ex_rw_q, ex_mr_q;
    logic [REG_AW-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;
    // MEM and WB shadow stages
    logic              mem_valid_q, mem_rw_q, wb_valid_q, wb_rw_q;
    logic [REG_AW-1:0] mem_rd_q, wb_rd_q;

    logic              ex_load;

    // Select for one EX operand; the youngest producer (EX/MEM) wins over MEM/WB.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs, input logic use_rs);
        logic consumer;
        consumer = ex_valid_q && use_rs && (rs != '0);
        if (consumer && mem_valid_q && mem_rw_q && (mem_rd_q == rs)) begin
            return 2'd1;
        end else if (consumer && wb_valid_q && wb_rw_q && (wb_rd_q != '0) && (wb_rd_q == rs)) begin
            return 2'd2;
        end
        return 2'd0;
    endfunction

    // Load-use detection and forwarding selects, all combinational from current state.
    always_comb begin
        stall = 1'b0;
        if (id_valid && ex_valid_q && ex_mr_q && (ex_rd_q != '0) && !flush) begin
            stall = (id_use_rs1 && (id_rs1 == ex_rd_q)) || (id_use_rs2 && (id_rs2 == ex_rd_q));
        end
        fwd_a_sel = fwd_sel(ex_rs1_q, ex_use_rs1_q);
        fwd_b_sel = fwd_sel(ex_rs2_q, ex_use_rs2_q);
        ex_load   = id_valid && !stall && !flush;
    end

    // Shadow pipeline advance; EX takes the ID instruction or a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q   <= 1'b0;
            ex_rs1_q     <= '0;
            ex_rs2_q     <= '0;
            ex_use_rs1_q <= 1'b0;
            ex_use_rs2_q <= 1'b0;
            ex_rd_q      <= '0;
            ex_rw_q      <= 1'b0;
            ex_mr_q      <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_rd_q     <= '0;
            mem_rw_q     <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_rw_q      <= 1'b0;
        end else begin
            wb_valid_q   <= mem_valid_q;
            wb_rd_q      <= mem_rd_q;
            wb_rw_q      <= mem_rw_q;
            mem_valid_q  <= ex_valid_q;
            mem_rd_q     <= ex_rd_q;
            mem_rw_q     <= ex_rw_q;
            ex_valid_q   <= ex_load;
            ex_rs1_q     <= ex_load ? id_rs1 : '0;
            ex_rs2_q     <= ex_load ? id_rs2 : '0;
            ex_use_rs1_q <= ex_load && id_use_rs1;
            ex_use_rs2_q <= ex_load && id_use_rs2;
            ex_rd_q      <= ex_load ? id_rd : '0;
            ex_rw_q      <= ex_load && id_reg_write;
            ex_mr_q      <= ex_load && id_mem_read;
        end
    end

`ifdef HAZARD_STALL_STATS_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    // Saturating count of stall cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: table of per-cycle ID inputs with expected
// stall/forwarding outputs, plus hand-written reset and counter-saturation sequences.
module tb_hazard_fwd_ctrl;

`ifdef HAZARD_STALL_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic       id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [1:0] fwd_a_sel, fwd_b_sel, sat_fwd_a, sat_fwd_b;
    logic       stall, sat_stall;
    logic [15:0] stall_count;
    logic [2:0]  sat_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.REG_AW(5), .STALL_CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .stall_count(stall_count)
    );

    // Narrow counter copy so saturation is reachable in a short run.
    hazard_fwd_ctrl #(.REG_AW(5), .STALL_CNT_W(3)) dut_sat (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .fwd_a_sel(sat_fwd_a), .fwd_b_sel(sat_fwd_b), .stall(sat_stall), .stall_count(sat_count)
    );

    typedef struct {
        logic       v, u1, u2, rw, mr, fl;
        logic [4:0] rs1, rs2, rd;
        logic       es;
        logic [1:0] ea, eb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                logic [4:0] rd, logic rw, logic mr, logic fl,
                                logic es, logic [1:0] ea, logic [1:0] eb);
        vec_t r;
        r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.rd = rd;
        r.rw = rw; r.mr = mr; r.fl = fl; r.es = es; r.ea = ea; r.eb = eb;
        return r;
    endfunction

    function automatic vec_t nop(logic [1:0] ea, logic [1:0] eb);
        return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ea, eb);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        id_valid = r.v; id_rs1 = r.rs1; id_rs2 = r.rs2; id_use_rs1 = r.u1; id_use_rs2 = r.u2;
        id_rd = r.rd; id_reg_write = r.rw; id_mem_read = r.mr; flush = r.fl;
    endtask

    initial begin
        // ---- reset state ----
        #3;
        check("reset_stall", stall, 0);
        check("reset_fwd_a", fwd_a_sel, 0);
        check("reset_fwd_b", fwd_b_sel, 0);
        check("reset_count", stall_count, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // ---- vector table: one row per cycle ----
        // add x5,x1,x2 ; sub x6,x5,x3
        vecs.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 3, 1, 1, 6, 1, 0, 0, 0, 0, 0));
        vecs.push_back(nop(1, 0));
        vecs.push_back(nop(0, 0));
        vecs.push_back(nop(0, 0));
        // add x5 ; nop ; or x7,x4,x5
        vecs.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0));
        vecs.push_back(nop(0, 0));
        vecs.push_back(mk(1, 4, 5, 1, 1, 7, 1, 0, 0, 0, 0, 0));
        vecs.push_back(nop(0, 2));
        vecs.push_back(nop(0, 0));
        vecs.push_back(nop(0, 0));
        // lw x8,0(x1) ; add x9,x8,x8 (stall one cycle, ID held)
        vecs.push_back(mk(1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 0, 0, 0));
        vecs.push_back(nop(2, 2));
        vecs.push_back(nop(0, 0));
        vecs.push_back(nop(0, 0));
        // add x5 ; add x5 ; sub x6,x5,x5
        vecs.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0));
        vecs.push_back(nop(1, 1));
        vecs.push_back(nop(0, 0));
        vecs.push_back(nop(0, 0));
        // add x0,x1,x2 ; sub x3,x0,x0
        vecs.push_back(mk(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 3, 1, 0, 0, 0, 0, 0));
        vecs.push_back(nop(0, 0));
        vecs.push_back(nop(0, 0));
        vecs.push_back(nop(0, 0));
        // lw x0 ; add x9,x0,x0 (no stall on x0)
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 9, 1, 0, 0, 0, 0, 0));
        vecs.push_back(nop(0, 0));
        vecs.push_back(nop(0, 0));
        vecs.push_back(nop(0, 0));
        // lw x8 ; add x9,x8,x8 with flush in the would-be stall cycle
        vecs.push_back(mk(1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 1, 0, 0, 0));
        vecs.push_back(nop(0, 0));
        vecs.push_back(nop(0, 0));
        vecs.push_back(nop(0, 0));
        // writer with rw=0, then consumer of x5: no forwarding
        vecs.push_back(mk(1, 1, 0, 1, 0, 5, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 0, 0));
        vecs.push_back(nop(0, 0));
        vecs.push_back(nop(0, 0));
        // invalid writer of x5, then consumer: no forwarding
        vecs.push_back(mk(0, 1, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 0, 0));
        vecs.push_back(nop(0, 0));
        vecs.push_back(nop(0, 0));
        // lw x7 ; add x10,x1,x7 (load-use through rs2)
        vecs.push_back(mk(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 7, 1, 1, 10, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 7, 1, 1, 10, 1, 0, 0, 0, 0, 0));
        vecs.push_back(nop(0, 2));
        vecs.push_back(nop(0, 0));
        vecs.push_back(nop(0, 0));
        // lw x8 ; add x9,x8,x2 ; sub x10,x8,x8 (second consumer, no stall)
        vecs.push_back(mk(1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8, 2, 1, 1, 9, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 8, 2, 1, 1, 9, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8, 8, 1, 1, 10, 1, 0, 0, 0, 2, 0));
        vecs.push_back(nop(0, 0));
        vecs.push_back(nop(0, 0));
        vecs.push_back(nop(0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            check($sformatf("row%0d_stall", i), stall, vecs[i].es);
            check($sformatf("row%0d_fwd_a", i), fwd_a_sel, vecs[i].ea);
            check($sformatf("row%0d_fwd_b", i), fwd_b_sel, vecs[i].eb);
            @(negedge clk);
        end
        check("count_after_table", stall_count, StatsEn ? 3 : 0);

        // ---- reset in the middle of a stall with live forwarding ----
        drive(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0));   // add x5,x1,x2
        @(negedge clk);
        drive(mk(1, 5, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0));   // lw x8,0(x5)
        @(negedge clk);
        drive(mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 0, 0, 0));   // add x9,x8,x8
        #1;
        check("pre_reset_stall", stall, 1);
        check("pre_reset_fwd_a", fwd_a_sel, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_stall", stall, 0);
        check("async_reset_fwd_a", fwd_a_sel, 0);
        check("async_reset_fwd_b", fwd_b_sel, 0);
        check("async_reset_count", stall_count, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("post_reset_stall", stall, 0);
        @(negedge clk);
        // add x9 must have entered EX on the first edge; sub x11,x9 then sees it in MEM
        drive(mk(1, 9, 0, 1, 0, 11, 1, 0, 0, 0, 0, 0));
        #1;
        check("post_reset_ex_fwd_a", fwd_a_sel, 0);
        @(negedge clk);
        drive(nop(0, 0));
        #1;
        check("post_reset_sampled_id", fwd_a_sel, 1);
        @(negedge clk);

        // ---- forced stalls: a self-dependent load held in ID stalls every other cycle ----
        drive(mk(1, 8, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0));
        for (int k = 0; k < 22; k++) begin
            #1;
            check($sformatf("forced_stall%0d", k), stall, k % 2);
            @(negedge clk);
        end
        drive(nop(0, 0));
        @(negedge clk);
        check("count_forced", stall_count, StatsEn ? 11 : 0);
        check("count_saturated", sat_count, StatsEn ? 7 : 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
